// File: rtl/bids22_pkg.sv
// Shared types for the bids22 host command sequencer: opcodes, error codes,
// winner encoding, sequencer state encoding and the FIFO entry layout.
package bids22_pkg;

    typedef enum logic [3:0] {
        OP_NOOP       = 4'h0,
        OP_UNLOCK     = 4'h1,
        OP_LOCK       = 4'h2,
        OP_LOADX      = 4'h3,
        OP_LOADY      = 4'h4,
        OP_LOADZ      = 4'h5,
        OP_SETXYZMASK = 4'h6,
        OP_SETTIMER   = 4'h7,
        OP_BIDCHARGE  = 4'h8,
        OP_RUN_ROUND  = 4'hF
    } opcode_e;

    localparam logic [1:0] ERR_OK             = 2'b00;
    localparam logic [1:0] ERR_ROUND_INACTIVE = 2'b01;
    localparam logic [1:0] ERR_NO_FUNDS       = 2'b10;
    localparam logic [1:0] ERR_MASKED         = 2'b11;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_Y    = 2'b10,
        WIN_Z    = 2'b11
    } winner_e;

    // Sequencer state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t S_IDLE  = 3'd0;
    localparam seq_state_t S_ISSUE = 3'd1;
    localparam seq_state_t S_CHECK = 3'd2;
    localparam seq_state_t S_ROUND = 3'd3;
    localparam seq_state_t S_WAIT  = 3'd4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_t;

    // A tie or an empty field reports no winner.
    function automatic winner_e encode_winner(input logic x, input logic y, input logic z);
        case ({x, y, z})
            3'b100:  return WIN_X;
            3'b010:  return WIN_Y;
            3'b001:  return WIN_Z;
            default: return WIN_NONE;
        endcase
    endfunction

    function automatic logic is_pass_through(input logic [3:0] op);
        return op <= OP_BIDCHARGE;
    endfunction

endpackage

// File: rtl/bids_cmd_sequencer_if.sv
// Host-side command handshake into the sequencer's command FIFO.
interface bids_cmd_sequencer_if;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_op;
    logic [31:0] host_data;

    modport master (output host_valid, output host_op, output host_data, input host_ready);
    modport slave  (input host_valid, input host_op, input host_data, output host_ready);
endinterface

// File: rtl/bids_cmd_fifo.sv
// Command FIFO: registered empty/full, no write-through, power-of-2 depth.
module bids_cmd_fifo
    import bids22_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  cmd_t                     wr_cmd,
    input  logic                     pop,
    output cmd_t                     rd_cmd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_cmd  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_cmd;
    end

endmodule

// File: rtl/bids_cmd_sequencer.sv
// Replays buffered host commands onto the bids22 controller pins, reports per-command
// err, and runs timed rounds whose result is captured when roundOver asserts.
module bids_cmd_sequencer
    import bids22_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned RESULT_TIMEOUT = 1024,
    parameter logic [3:0]  OP_RUN         = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    bids_cmd_sequencer_if.slave host,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic        ready,
    input  logic [1:0]  err,
    input  logic        roundOver,
    input  logic [31:0] maxBid,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    output logic        busy,
    output logic        cmd_done,
    output logic [1:0]  cmd_err,
    output logic        cmd_reject,
    output logic        result_valid,
    output logic [31:0] result_maxBid,
    output logic [1:0]  result_winner,
    output logic        result_timeout
);
    localparam int unsigned TW = $clog2(RESULT_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(RESULT_TIMEOUT - 1);

    seq_state_t                  state;
    logic [31:0]                 cnt;
    logic [TW-1:0]               tmo;
    cmd_t                        head;
    cmd_t                        wr_cmd;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;

    assign wr_cmd          = '{op: host.host_op, data: host.host_data};
    assign host.host_ready = !fifo_full;
    assign pop             = (state == S_IDLE) && !fifo_empty && ready;
    assign busy            = (state != S_IDLE) || (fifo_count != '0);

    bids_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (host.host_valid),
        .wr_cmd  (wr_cmd),
        .pop     (pop),
        .rd_cmd  (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            tmo            <= '0;
            C_op           <= OP_NOOP;
            C_data         <= '0;
            C_start        <= 1'b0;
            cmd_done       <= 1'b0;
            cmd_err        <= ERR_OK;
            cmd_reject     <= 1'b0;
            result_valid   <= 1'b0;
            result_maxBid  <= '0;
            result_winner  <= WIN_NONE;
            result_timeout <= 1'b0;
        end else begin
            cmd_done     <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    C_op    <= OP_NOOP;
                    C_start <= 1'b0;
                    if (pop) begin
                        if (is_pass_through(head.op)) begin
                            state  <= S_ISSUE;
                            C_op   <= head.op;
                            C_data <= head.data;
                        end else if (head.op == OP_RUN && head.data != '0) begin
                            state   <= S_ROUND;
                            cnt     <= head.data;
                            C_start <= 1'b1;
                        end else begin
                            cmd_done   <= 1'b1;
                            cmd_reject <= 1'b1;
                            cmd_err    <= ERR_OK;
                        end
                    end
                end
                S_ISSUE: begin
                    C_op  <= OP_NOOP;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // The controller answers the cycle after the opcode is presented.
                    cmd_err    <= err;
                    cmd_done   <= 1'b1;
                    cmd_reject <= 1'b0;
                    state      <= S_IDLE;
                end
                S_ROUND: begin
                    if (cnt == 32'd1) begin
                        C_start <= 1'b0;
                        tmo     <= '0;
                        state   <= S_WAIT;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_WAIT: begin
                    if (roundOver) begin
                        result_valid   <= 1'b1;
                        result_timeout <= 1'b0;
                        result_maxBid  <= maxBid;
                        result_winner  <= encode_winner(X_win, Y_win, Z_win);
                        state          <= S_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        result_valid   <= 1'b1;
                        result_timeout <= 1'b1;
                        result_maxBid  <= '0;
                        result_winner  <= WIN_NONE;
                        state          <= S_IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bids_cmd_sequencer.sv
// Directed bench for bids_cmd_sequencer: command framing, FIFO backpressure,
// timed rounds, result timeout, rejects and asynchronous reset mid-round.
module tb_bids_cmd_sequencer;
    import bids22_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready;
    logic [1:0]  err;
    logic        roundOver;
    logic [31:0] maxBid;
    logic        X_win, Y_win, Z_win;
    logic        busy, cmd_done, cmd_reject;
    logic [1:0]  cmd_err;
    logic        result_valid, result_timeout;
    logic [31:0] result_maxBid;
    logic [1:0]  result_winner;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    bids_cmd_sequencer_if host_bus ();

    bids_cmd_sequencer #(
        .FIFO_DEPTH     (4),
        .RESULT_TIMEOUT (8),
        .OP_RUN         (4'hF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .host           (host_bus),
        .C_op           (C_op),
        .C_data         (C_data),
        .C_start        (C_start),
        .ready          (ready),
        .err            (err),
        .roundOver      (roundOver),
        .maxBid         (maxBid),
        .X_win          (X_win),
        .Y_win          (Y_win),
        .Z_win          (Z_win),
        .busy           (busy),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .cmd_reject     (cmd_reject),
        .result_valid   (result_valid),
        .result_maxBid  (result_maxBid),
        .result_winner  (result_winner),
        .result_timeout (result_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] data);
        host_bus.host_valid = 1'b1;
        host_bus.host_op    = op;
        host_bus.host_data  = data;
        tick();
        host_bus.host_valid = 1'b0;
    endtask

    task automatic wait_issue(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (C_op != 4'd0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  exp_op  [5];
        logic [31:0] exp_dat [5];
        int          last;
        int          n;
        bit          seen;
        bit          bad;

        exp_op  = '{4'd4, 4'd5, 4'd7, 4'd8, 4'd1};
        exp_dat = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};

        host_bus.host_valid = 1'b0;
        host_bus.host_op    = 4'd0;
        host_bus.host_data  = 32'd0;
        ready = 1'b1; err = 2'b00; roundOver = 1'b0; maxBid = 32'd0;
        X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_c_op", 32'(C_op), 32'd0);
        check("rst_c_start", 32'(C_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_c_data", C_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_host_ready", 32'(host_bus.host_ready), 32'd1);
        check("rst_flags", {cmd_done, cmd_reject, cmd_err, result_valid, result_timeout, result_winner}, 32'd0);
        check("rst_max_bid", result_maxBid, 32'd0);

        // 1: single LoadX framing
        push(OP_LOADX, 32'd500);
        check("t1_c_op_before", 32'(C_op), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_c_op_issue", 32'(C_op), 32'd3);
        check("t1_c_data_issue", C_data, 32'd500);
        tick();
        check("t1_c_op_check", 32'(C_op), 32'd0);
        check("t1_c_data_held", C_data, 32'd500);
        check("t1_done_early", 32'(cmd_done), 32'd0);
        tick();
        check("t1_cmd_done", 32'(cmd_done), 32'd1);
        check("t1_cmd_err", 32'(cmd_err), 32'd0);
        tick();
        check("t1_done_pulse", 32'(cmd_done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: backpressure with controller not ready, then in-order drain
        ready = 1'b0;
        err   = 2'b10;
        for (int i = 0; i < 4; i++) begin
            host_bus.host_valid = 1'b1;
            host_bus.host_op    = exp_op[i];
            host_bus.host_data  = exp_dat[i];
            tick();
        end
        host_bus.host_op   = exp_op[4];
        host_bus.host_data = exp_dat[4];
        check("t2_full", 32'(host_bus.host_ready), 32'd0);
        tick();
        tick();
        check("t2_stall_full", 32'(host_bus.host_ready), 32'd0);
        check("t2_stall_c_op", 32'(C_op), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        tick();
        check("t2_ready_after_pop", 32'(host_bus.host_ready), 32'd1);
        check("t2_op0", 32'(C_op), 32'(exp_op[0]));
        check("t2_dat0", C_data, exp_dat[0]);
        last = cyc;
        tick();
        host_bus.host_valid = 1'b0;
        check("t2_refull", 32'(host_bus.host_ready), 32'd0);
        for (int k = 1; k < 5; k++) begin
            wait_issue(seen);
            check("t2_issue_seen", 32'(seen), 32'd1);
            check("t2_op", 32'(C_op), 32'(exp_op[k]));
            check("t2_dat", C_data, exp_dat[k]);
            check("t2_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
        end
        tick();
        tick();
        check("t2_cmd_done", 32'(cmd_done), 32'd1);
        check("t2_cmd_err", 32'(cmd_err), 32'd2);
        err = 2'b00;
        tick();
        check("t2_drained", 32'(busy), 32'd0);

        // 3: six-cycle round, Y wins
        push(OP_RUN_ROUND, 32'd6);
        tick();
        check("t3_start", 32'(C_start), 32'd1);
        n = 0;
        while (C_start && n < 40) begin
            n++;
            tick();
        end
        check("t3_start_len", 32'(n), 32'd6);
        tick();
        tick();
        roundOver = 1'b1; maxBid = 32'd120; Y_win = 1'b1;
        check("t3_no_result_yet", 32'(result_valid), 32'd0);
        tick();
        check("t3_result_valid", 32'(result_valid), 32'd1);
        check("t3_max_bid", result_maxBid, 32'd120);
        check("t3_winner", 32'(result_winner), 32'd2);
        check("t3_timeout", 32'(result_timeout), 32'd0);
        roundOver = 1'b0; maxBid = 32'd999; Y_win = 1'b0;
        tick();
        check("t3_valid_pulse", 32'(result_valid), 32'd0);
        check("t3_max_bid_hold", result_maxBid, 32'd120);
        check("t3_idle", 32'(busy), 32'd0);

        // 3b: one-cycle round, X and Z both flagged -> no winner
        push(OP_RUN_ROUND, 32'd1);
        tick();
        check("t3b_start", 32'(C_start), 32'd1);
        tick();
        check("t3b_start_fell", 32'(C_start), 32'd0);
        roundOver = 1'b1; maxBid = 32'd77; X_win = 1'b1; Z_win = 1'b1;
        tick();
        check("t3b_valid", 32'(result_valid), 32'd1);
        check("t3b_max_bid", result_maxBid, 32'd77);
        check("t3b_tie_winner", 32'(result_winner), 32'd0);
        roundOver = 1'b0; maxBid = 32'd0; X_win = 1'b0; Z_win = 1'b0;

        // 4: round with no roundOver times out after 8 WAIT cycles
        push(OP_RUN_ROUND, 32'd2);
        tick();
        n = 0;
        while (C_start && n < 40) begin
            n++;
            tick();
        end
        check("t4_start_len", 32'(n), 32'd2);
        n = 0;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
        check("t4_wait_cycles", 32'(n), 32'd8);
        check("t4_valid", 32'(result_valid), 32'd1);
        check("t4_timeout", 32'(result_timeout), 32'd1);
        check("t4_winner", 32'(result_winner), 32'd0);
        check("t4_max_bid", result_maxBid, 32'd0);

        // 5: rejects (zero-length run, reserved opcode), then a normal command clears reject
        push(OP_RUN_ROUND, 32'd0);
        tick();
        check("t5a_done", 32'(cmd_done), 32'd1);
        check("t5a_reject", 32'(cmd_reject), 32'd1);
        check("t5a_no_start", 32'(C_start), 32'd0);
        push(4'hA, 32'd77);
        tick();
        check("t5b_done", 32'(cmd_done), 32'd1);
        check("t5b_reject", 32'(cmd_reject), 32'd1);
        check("t5b_c_op", 32'(C_op), 32'd0);
        check("t5b_no_start", 32'(C_start), 32'd0);
        push(OP_LOCK, 32'd0);
        tick();
        check("t5c_c_op", 32'(C_op), 32'd2);
        tick();
        tick();
        check("t5c_done", 32'(cmd_done), 32'd1);
        check("t5c_reject_clear", 32'(cmd_reject), 32'd0);

        // 6: asynchronous reset in ROUND cycle 3 of 10 with a command queued
        push(OP_RUN_ROUND, 32'd10);
        tick();
        push(OP_LOADX, 32'd1);
        tick();
        check("t6_in_round", 32'(C_start), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_start", 32'(C_start), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        #3;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (result_valid || C_op != 4'd0 || C_start) bad = 1'b1;
        end
        check("t6_quiet_after_reset", 32'(bad), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_host_ready", 32'(host_bus.host_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/bids_cmd_sequencer.md
Name: bids_cmd_sequencer

Overview:
- Host-side command sequencer sitting directly upstream of the bids22 auction controller.
- Buffers host commands in a small FIFO and replays them onto the controller's C_op/C_data/C_start pins with correct one-cycle framing.
- Reports the controller's err response per command.
- Runs timed rounds: holds C_start for a programmed cycle count, then captures maxBid and the winner when roundOver asserts.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
RESULT_TIMEOUT, 1024, max cycles to wait for roundOver after C_start drops
OP_RUN, 4'hF, sequencer-local opcode "run round"; C_data = round length in cycles

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
host_valid  in  1  host command present
host_ready  out  1  FIFO can accept (= !full)
host_op  in  4  command opcode (0-8 pass-through, OP_RUN local)
host_data  in  32  command operand
C_op  out  4  to controller opcode
C_data  out  32  to controller operand
C_start  out  1  to controller round-active
ready  in  1  controller ready
err  in  2  controller error code
roundOver  in  1  controller round complete
maxBid  in  32  controller winning amount
X_win  in  1  controller win flag, bidder X
Y_win  in  1  controller win flag, bidder Y
Z_win  in  1  controller win flag, bidder Z
busy  out  1  FSM not IDLE or FIFO non-empty
cmd_done  out  1  one-cycle pulse per completed pass-through command or rejected OP_RUN
cmd_err  out  2  err sampled for that command; valid with cmd_done
cmd_reject  out  1  OP_RUN with length 0 or opcode 9-14; valid with cmd_done
result_valid  out  1  one-cycle pulse, round result captured
result_maxBid  out  32  captured maxBid
result_winner  out  2  00 none/tie, 01 X, 10 Y, 11 Z
result_timeout  out  1  roundOver never seen; valid with result_valid

Behaviour:
- Reset (async assert, sync release):
  - FIFO flushed; FSM to IDLE.
  - C_op=0 (NoOp), C_data=0, C_start=0.
  - All pulses, flags, result_*, cmd_err = 0.
  - host_ready=1 once reset_n=1.
- Reset mid-round drops C_start immediately (async).
- FIFO:
  - Push when host_valid&&host_ready.
  - Simultaneous push+pop permitted; count unchanged.
  - No write-through: an entry written at edge N is poppable at edge N+1 at the earliest.
- FSM:
  - IDLE:
    - C_op=NoOp, C_start=0.
    - If FIFO non-empty and ready==1: pop.
      - op 0-8 -> ISSUE.
      - OP_RUN with data!=0 -> ROUND, cnt=data.
      - Otherwise: cmd_done=1 and cmd_reject=1 next cycle, stay IDLE.
    - ready==0 stalls with no pop.
  - ISSUE (1 cycle): C_op=op, C_data=data. -> CHECK.
  - CHECK (1 cycle):
    - C_op=NoOp, C_data held.
    - cmd_err<=err, cmd_done pulse.
    - -> IDLE.
    - Command-to-command spacing: 3 cycles minimum.
  - ROUND:
    - C_start=1, C_op=NoOp.
    - cnt decrements each cycle; when cnt==1, -> WAIT.
    - C_start is high for exactly `data` cycles.
    - data=32'hFFFFFFFF is legal; no wrap, cnt is 32-bit down-counter.
  - WAIT:
    - C_start=0; tmo counter from 0.
    - On roundOver==1: capture maxBid and winner, result_valid pulse, -> IDLE.
    - If tmo reaches RESULT_TIMEOUT-1 without roundOver: result_valid=1, result_timeout=1, result_maxBid=0, winner=00, -> IDLE.
    - roundOver and timeout in same cycle: roundOver wins.
- Winner encoding:
  - Exactly one of X/Y/Z_win high -> encode as listed.
  - Zero or more than one high -> 00.
- result_* hold until the next capture.
- cmd_err/cmd_reject hold until the next cmd_done.
- busy = (state!=IDLE) || !empty.
- roundOver or err changes outside CHECK/WAIT are ignored.

Decomposition:
- Package bids22_pkg:
  - opcode enum: NoOp 0, Unlock 1, Lock 2, LoadX 3, LoadY 4, LoadZ 5, SetXYZmask 6, SetTimer 7, BidCharge 8, RunRound 4'hF.
  - err code constants: 00 ok, 01 round inactive, 10 insufficient funds, 11 masked/invalid.
  - winner enum.
  - sequencer state enum.
- Sub-module bids_cmd_fifo: 36-bit wide, FIFO_DEPTH deep, with count/full/empty; same clk/reset_n.

Test Plan:
1. Push LoadX(32'd500) with ready=1, err=00 -> C_op=3, C_data=500 for exactly 1 cycle, 2 cycles after push. cmd_done 1 cycle later, cmd_err=00.
2. Push 5 commands back-to-back with FIFO_DEPTH=4 and ready=0 -> host_ready low after 4th; nothing issued. Raise ready -> 4 commands issued in order, 3 cycles apart; 5th accepted after first pop.
3. Push OP_RUN(data=6), controller asserts roundOver 3 cycles after C_start falls with maxBid=120, Y_win=1 -> C_start high exactly 6 cycles; result_valid pulse, result_maxBid=120, result_winner=10, result_timeout=0.
4. OP_RUN(data=2), RESULT_TIMEOUT=8, roundOver never asserted -> result_valid on 8th WAIT cycle, result_timeout=1, result_winner=00.
5. OP_RUN(data=0), then op 4'hA -> two cmd_done pulses with cmd_reject=1; C_start never asserted; C_op stays 0.
6. Deassert reset_n during ROUND cycle 3 of 10 -> C_start=0 asynchronously; FIFO empty, busy=0, host_ready=1 after release; no result_valid.
